// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter that owns a shared 4:1 mux path.
// A grant is held while the owner keeps requesting, but at most MAX_HOLD
// consecutive cycles when other requesters are waiting. The mux select,
// the output data and its valid flag are all registered.
module mux_rr_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e              state_q;
  logic [1:0]          ptr_q;
  logic [1:0]          sel_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [3:0]          gnt_q;
  logic [DATA_W-1:0]   out_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [3:0]          owner_bit_c;
  logic [3:0]          cand_c;
  logic                owner_req_c;
  logic                pick_found_c;
  logic [1:0]          pick_idx_c;
  logic [1:0]          pick_try_c;
  logic                grant_c;
  logic [1:0]          grant_idx_c;
  logic                to_idle_c;
  logic                hold_inc_c;
  logic [DATA_W-1:0]   mux_c;

  // Candidate set: while owned, the owner is excluded so a timeout or a
  // release hands the path to someone else when possible.
  always_comb begin
    owner_bit_c = 4'b0001 << sel_q;
    cand_c      = (state_q == OWNED) ? (req & ~owner_bit_c) : req;
    owner_req_c = |(req & owner_bit_c);
  end

  // First candidate in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = ptr_q;
    pick_try_c   = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      pick_try_c = ptr_q + 2'(i);
      if (!pick_found_c && cand_c[pick_try_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = pick_try_c;
      end
    end
  end

  // Arbitration decision for the coming edge.
  always_comb begin
    grant_c     = 1'b0;
    grant_idx_c = pick_idx_c;
    to_idle_c   = 1'b0;
    hold_inc_c  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_c = pick_found_c;
      end
      OWNED: begin
        if (!owner_req_c) begin
          // Release: hand over with no idle bubble, or fall idle.
          grant_c   = pick_found_c;
          to_idle_c = !pick_found_c;
        end else if (hold_q != HOLD_LAST) begin
          hold_inc_c = 1'b1;
        end else begin
          // Hold limit reached: pass on if anyone waits, else re-grant owner.
          grant_c     = 1'b1;
          grant_idx_c = pick_found_c ? pick_idx_c : sel_q;
        end
      end
      default: ;
    endcase
  end

  // Registered 4:1 mux path driven by the current select.
  always_comb begin
    case (sel_q)
      2'd0:    mux_c = i0;
      2'd1:    mux_c = i1;
      2'd2:    mux_c = i2;
      default: mux_c = i3;
    endcase
  end

  // Arbiter FSM and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      hold_q      <= '0;
      gnt_q       <= 4'b0000;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= busy_q;
      if (busy_q) begin
        out_q <= mux_c;
      end
      if (grant_c) begin
        state_q <= OWNED;
        gnt_q   <= 4'b0001 << grant_idx_c;
        sel_q   <= grant_idx_c;
        ptr_q   <= grant_idx_c + 2'd1;
        hold_q  <= '0;
        busy_q  <= 1'b1;
      end else if (to_idle_c) begin
        state_q <= IDLE;
        gnt_q   <= 4'b0000;
        busy_q  <= 1'b0;
      end else if (hold_inc_c) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, formula-checked
// multi-cycle sequences and a reference model for random traffic, all
// feeding one scoreboard queue.
module tb_mux_rr_arbiter;

  localparam int unsigned DW   = 4;
  localparam int unsigned HOLD = 4;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] out;
    logic          ov;
    logic          busy;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    exp_t       e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] d [4];
  logic [3:0]    gnt;
  logic          s1, s0, out_valid, busy;
  logic [DW-1:0] out;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q [$];

  // Reference model state.
  int            m_own  = -1;
  int            m_ptr  = 0;
  int            m_hold = 0;
  int            m_sel  = 0;
  logic [DW-1:0] m_out  = '0;
  logic          m_ov   = 1'b0;
  logic          m_busy = 1'b0;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(d[0]), .i1(d[1]), .i2(d[2]), .i3(d[3]),
    .gnt(gnt), .s1(s1), .s0(s0), .out(out),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] rq, input int excl);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
      if (rq[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq);
    int g;
    g = -1;
    if (!r) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      m_out = '0; m_ov = 1'b0; m_busy = 1'b0;
    end else begin
      m_ov = m_busy;
      if (m_busy) m_out = d[m_sel];
      if (m_own < 0) begin
        g = search(rq, -1);
      end else if (!rq[m_own]) begin
        g = search(rq, m_own);
        if (g < 0) m_own = -1;
      end else if (m_hold < HOLD - 1) begin
        m_hold++;
      end else begin
        g = search(rq, m_own);
        if (g < 0) g = m_own;
      end
      if (g >= 0) begin
        m_own = g; m_sel = g; m_ptr = (g + 1) % 4; m_hold = 0;
      end
      m_busy = (m_own >= 0);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.gnt  = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.out  = m_out;
    e.ov   = m_ov;
    e.busy = m_busy;
    return e;
  endfunction

  // Drive one cycle, queue its expectation, then check after the edge.
  task automatic step(input string nm, input logic r, input logic [3:0] rq,
                      input bit use_given, input exp_t given);
    exp_t e, act;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    model_step(r, rq);
    sb_q.push_back(use_given ? given : model_exp());
    @(posedge clk);
    #1;
    act = '{gnt, {s1, s0}, out, out_valid, busy};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got gnt=%b sel=%b out=%h ov=%b busy=%b, expected gnt=%b sel=%b out=%h ov=%b busy=%b",
                 nm, act.gnt, act.sel, act.out, act.ov, act.busy,
                 e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask

  initial begin
    vec_t tbl [13];
    exp_t e;
    logic [3:0] rq;

    tbl[0]  = '{1'b0, 4'b0000, '{4'b0000, 2'b00, 4'h0, 1'b0, 1'b0}};
    tbl[1]  = '{1'b1, 4'b0101, '{4'b0001, 2'b00, 4'h0, 1'b0, 1'b1}};
    tbl[2]  = '{1'b1, 4'b0101, '{4'b0001, 2'b00, 4'h5, 1'b1, 1'b1}};
    tbl[3]  = '{1'b1, 4'b0000, '{4'b0000, 2'b00, 4'h5, 1'b1, 1'b0}};
    tbl[4]  = '{1'b1, 4'b0000, '{4'b0000, 2'b00, 4'h5, 1'b0, 1'b0}};
    tbl[5]  = '{1'b1, 4'b0100, '{4'b0100, 2'b10, 4'h5, 1'b0, 1'b1}};
    tbl[6]  = '{1'b1, 4'b1100, '{4'b0100, 2'b10, 4'h7, 1'b1, 1'b1}};
    tbl[7]  = '{1'b1, 4'b1000, '{4'b1000, 2'b11, 4'h7, 1'b1, 1'b1}};
    tbl[8]  = '{1'b1, 4'b0001, '{4'b0001, 2'b00, 4'h8, 1'b1, 1'b1}};
    tbl[9]  = '{1'b1, 4'b0001, '{4'b0001, 2'b00, 4'h5, 1'b1, 1'b1}};
    tbl[10] = '{1'b0, 4'b0001, '{4'b0000, 2'b00, 4'h0, 1'b0, 1'b0}};
    tbl[11] = '{1'b1, 4'b1000, '{4'b1000, 2'b11, 4'h0, 1'b0, 1'b1}};
    tbl[12] = '{1'b1, 4'b0000, '{4'b0000, 2'b11, 4'h8, 1'b1, 1'b0}};

    d[0] = 4'h5; d[1] = 4'h6; d[2] = 4'h7; d[3] = 4'h8;
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, 1'b1, tbl[i].e);
    end

    // Full contention: 4-cycle windows rotating 0,1,2,3,0.
    d[0] = 4'h1; d[1] = 4'h0; d[2] = 4'h1; d[3] = 4'h0;
    step("rr_reset", 1'b0, 4'b0000, 1'b1, '0);
    for (int k = 1; k <= 20; k++) begin
      int w, wo;
      w  = ((k - 1) / 4) % 4;
      wo = ((k - 2) / 4) % 4;
      e.gnt  = 4'b0001 << w;
      e.sel  = 2'(w);
      e.ov   = (k >= 2);
      e.out  = (k >= 2) ? d[wo] : '0;
      e.busy = 1'b1;
      step($sformatf("rr_cyc%0d", k), 1'b1, 4'b1111, 1'b1, e);
    end

    // Lone requester past the hold limit: re-granted, never idle.
    d[0] = 4'h3; d[1] = 4'h9; d[2] = 4'h5; d[3] = 4'h6;
    step("solo_reset", 1'b0, 4'b0000, 1'b1, '0);
    for (int k = 1; k <= 10; k++) begin
      e.gnt  = 4'b0010;
      e.sel  = 2'b01;
      e.ov   = (k >= 2);
      e.out  = (k >= 2) ? 4'h9 : 4'h0;
      e.busy = 1'b1;
      step($sformatf("solo_cyc%0d", k), 1'b1, 4'b0010, 1'b1, e);
    end

    // Random traffic against the reference model.
    rq = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < 4; j++) d[j] = DW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      step($sformatf("rand%0d", k), ($urandom_range(0, 39) != 0), rq, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
